// File: rtl/seg7_stream_ctrl_if.sv
// Read-side handshake between the UART RX FIFO (master) and the display controller (slave).
interface seg7_stream_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_rd;

  modport master (output rx_data, output rx_empty, input rx_rd);
  modport slave  (input rx_data, input rx_empty, output rx_rd);
endinterface

// File: rtl/seg7_stream_ctrl.sv
// Pops characters from the RX FIFO into a shifting character buffer and
// time-multiplexes them onto a common-anode 7-segment display.
module seg7_stream_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  seg7_stream_ctrl_if.slave rx,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

  state_t            state;
  logic              rd_q;
  logic [7:0]        cap_byte;
  logic [7:0]        chr [DIGITS];
  logic [DIGITS-1:0] dpf;
  logic [DIV_W-1:0]  div;
  logic [IDX_W-1:0]  idx;

  function automatic logic [6:0] decode(input logic [7:0] ch);
    logic [6:0] s;
    case (ch)
      8'h30:        s = 7'h40;
      8'h31:        s = 7'h79;
      8'h32:        s = 7'h24;
      8'h33:        s = 7'h30;
      8'h34:        s = 7'h19;
      8'h35:        s = 7'h12;
      8'h36:        s = 7'h02;
      8'h37:        s = 7'h78;
      8'h38:        s = 7'h00;
      8'h39:        s = 7'h10;
      8'h41, 8'h61: s = 7'h08;
      8'h42, 8'h62: s = 7'h03;
      8'h43, 8'h63: s = 7'h46;
      8'h44, 8'h64: s = 7'h21;
      8'h45, 8'h65: s = 7'h06;
      8'h46, 8'h66: s = 7'h0E;
      8'h2D:        s = 7'h3F;
      default:      s = 7'h7F;
    endcase
    return s;
  endfunction

  // Reset in the POP cycle suppresses the strobe so the FIFO keeps its head byte.
  assign rx.rx_rd = rd_q & ~rst;

  // Read FSM and character buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_q  <= 1'b0;
      dpf   <= '0;
      for (int i = 0; i < DIGITS; i++) chr[i] <= 8'h20;
    end else begin
      case (state)
        IDLE: begin
          if (!rx.rx_empty) begin
            cap_byte <= rx.rx_data;
            rd_q     <= 1'b1;
            state    <= POP;
          end
        end
        POP: begin
          rd_q  <= 1'b0;
          state <= SETTLE;
          case (cap_byte)
            8'h0D: begin
              dpf <= '0;
              for (int i = 0; i < DIGITS; i++) chr[i] <= 8'h20;
            end
            8'h2E: dpf[0] <= 1'b1;
            default: begin
              for (int i = 1; i < DIGITS; i++) chr[i] <= chr[i-1];
              chr[0] <= cap_byte;
              dpf    <= dpf << 1;
            end
          endcase
        end
        SETTLE: state <= IDLE;
        default: begin
          state <= IDLE;
          rd_q  <= 1'b0;
        end
      endcase
    end
  end

  // Scan divider, digit index and registered display pins
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      if (div == DIV_LAST) begin
        div <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
      seg <= decode(chr[idx]);
      dp  <= ~dpf[idx];
      an  <= ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seg7_stream_ctrl.sv
// Bench for seg7_stream_ctrl with a small FIFO model, decode vector table and corner sequences.
module tb_seg7_stream_ctrl;
  localparam int DIGITS = 4;
  localparam int REFRESH_DIV = 4;

  logic clk;
  logic rst;
  logic [6:0] seg;
  logic dp;
  logic [DIGITS-1:0] an;

  seg7_stream_ctrl_if fifo_if ();

  seg7_stream_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .rx (fifo_if.slave),
    .seg(seg),
    .dp (dp),
    .an (an)
  );

  typedef struct {
    logic [7:0] ch;
    logic [6:0] seg;
  } dec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_pop = 0;
  logic [7:0] pend_q[$];
  logic [7:0] fq[$];
  logic [7:0] sb_q[$];
  logic [7:0] got_q[$];
  int pop_t[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // FIFO model: pops on a cycle where rx_rd is high, then appends pending pushes.
  initial begin
    logic prev_rd;
    prev_rd = 1'b0;
    fifo_if.rx_empty = 1'b1;
    fifo_if.rx_data = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (fifo_if.rx_rd) begin
        if (fq.size() == 0 || prev_rd) bad_pop++;
        else got_q.push_back(fq.pop_front());
        pop_t.push_back(cyc);
      end
      prev_rd = fifo_if.rx_rd;
      while (pend_q.size() != 0) fq.push_back(pend_q.pop_front());
      fifo_if.rx_empty = (fq.size() == 0);
      fifo_if.rx_data = (fq.size() != 0) ? fq[0] : 8'h00;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    pend_q.push_back(b);
    sb_q.push_back(b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend_q.size() != 0 || fq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("idle_timeout", 32'd1, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_digit(input int k, input logic [6:0] es, input logic ed, input string nm);
    logic [DIGITS-1:0] sel;
    int n = 0;
    sel = ~(DIGITS'(1) << k);
    while (an == sel && n < 40) begin @(negedge clk); n++; end
    while (an != sel && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk({nm, "_timeout"}, 32'd1, 32'd0);
    else begin
      chk({nm, "_seg"}, 32'(seg), 32'(es));
      chk({nm, "_dp"}, 32'(dp), 32'(ed));
    end
  endtask

  task automatic check_sb(input string nm);
    chk({nm, "_count"}, got_q.size(), sb_q.size());
    while (got_q.size() != 0 && sb_q.size() != 0)
      chk({nm, "_byte"}, 32'(got_q.pop_front()), 32'(sb_q.pop_front()));
    got_q.delete();
    sb_q.delete();
  endtask

  initial begin
    dec_t tbl[22];
    tbl[0]  = '{8'h30, 7'h40}; tbl[1]  = '{8'h31, 7'h79};
    tbl[2]  = '{8'h32, 7'h24}; tbl[3]  = '{8'h33, 7'h30};
    tbl[4]  = '{8'h34, 7'h19}; tbl[5]  = '{8'h35, 7'h12};
    tbl[6]  = '{8'h36, 7'h02}; tbl[7]  = '{8'h37, 7'h78};
    tbl[8]  = '{8'h38, 7'h00}; tbl[9]  = '{8'h39, 7'h10};
    tbl[10] = '{8'h41, 7'h08}; tbl[11] = '{8'h62, 7'h03};
    tbl[12] = '{8'h43, 7'h46}; tbl[13] = '{8'h64, 7'h21};
    tbl[14] = '{8'h45, 7'h06}; tbl[15] = '{8'h66, 7'h0E};
    tbl[16] = '{8'h2D, 7'h3F}; tbl[17] = '{8'h47, 7'h7F};
    tbl[18] = '{8'h61, 7'h08}; tbl[19] = '{8'h46, 7'h0E};
    tbl[20] = '{8'h5A, 7'h7F}; tbl[21] = '{8'h20, 7'h7F};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_rd", 32'(fifo_if.rx_rd), 32'd0);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_an", 32'(an), 32'hF);

    // Idle scan: each digit lit for REFRESH_DIV cycles, starting at digit 0.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("idle_an", 32'(an), 32'(4'(~(4'b0001 << (i / 4)))));
      chk("idle_seg", 32'(seg), 32'h7F);
      chk("idle_rd", 32'(fifo_if.rx_rd), 32'd0);
    end

    // "1234": four pops three cycles apart.
    pop_t.delete();
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    wait_idle();
    chk("burst_pops", pop_t.size(), 4);
    for (int i = 1; i < pop_t.size(); i++)
      chk("burst_gap", 32'(pop_t[i] - pop_t[i-1]), 32'd3);
    check_sb("burst_sb");
    check_digit(0, 7'h19, 1'b1, "d0_4");
    check_digit(1, 7'h30, 1'b1, "d1_3");
    check_digit(2, 7'h24, 1'b1, "d2_2");
    check_digit(3, 7'h79, 1'b1, "d3_1");

    // CR then "12.3": the dp flag travels with '2'.
    send(8'h0D); send(8'h31); send(8'h32); send(8'h2E); send(8'h33);
    wait_idle();
    check_sb("dp_sb");
    check_digit(0, 7'h30, 1'b1, "dp_d0");
    check_digit(1, 7'h24, 1'b0, "dp_d1");
    check_digit(2, 7'h79, 1'b1, "dp_d2");
    check_digit(3, 7'h7F, 1'b1, "dp_d3");

    // "AB" then CR clears digits and dp flags.
    send(8'h41); send(8'h42);
    wait_idle();
    check_digit(0, 7'h03, 1'b1, "ab_d0");
    check_digit(1, 7'h08, 1'b1, "ab_d1");
    check_digit(2, 7'h30, 1'b1, "ab_d2");
    check_digit(3, 7'h24, 1'b0, "ab_d3");
    send(8'h0D);
    wait_idle();
    for (int k = 0; k < DIGITS; k++) check_digit(k, 7'h7F, 1'b1, "cr_clr");
    check_sb("cr_sb");

    // Decode table, one character at a time into digit 0.
    for (int i = 0; i < 22; i++) begin
      send(tbl[i].ch);
      wait_idle();
      check_digit(0, tbl[i].seg, 1'b1, $sformatf("dec_%02h", tbl[i].ch));
    end
    check_digit(1, 7'h7F, 1'b1, "dec_prev_blank");
    check_sb("dec_sb");

    // Reset in the POP cycle: strobe dropped, byte re-read afterwards.
    pop_t.delete();
    send(8'h37);
    begin
      int n = 0;
      while (fifo_if.rx_rd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("rstpop_seen", 32'(fifo_if.rx_rd), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstpop_rd", 32'(fifo_if.rx_rd), 32'd0);
    chk("rstpop_fifo", fq.size(), 1);
    rst = 1'b0;
    wait_idle();
    chk("rstpop_pops", pop_t.size(), 1);
    check_sb("rstpop_sb");
    check_digit(0, 7'h78, 1'b1, "rstpop_d0");
    check_digit(1, 7'h7F, 1'b1, "rstpop_d1");
    check_digit(3, 7'h7F, 1'b1, "rstpop_d3");

    chk("pop_guard", bad_pop, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_stream_ctrl.md
Name: seg7_stream_ctrl

Overview:
Controller between the UART RX FIFO and a multiplexed common-anode 7-segment display. It pops received bytes from the FIFO with a paced read handshake and shifts each character into a DIGITS-deep character buffer; the newest character goes to the rightmost digit. It decodes each character to a segment pattern and time-multiplexes the digits with a programmable refresh divider. It sits directly downstream of the RX FIFO and drives the board display pins.

Parameters:
DIGITS, 4, number of display digits (1..8)
REFRESH_DIV, 100000, clk cycles each digit stays lit (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
rx_data  input  8  FIFO head byte, first-word-fall-through, valid while rx_empty=0
rx_empty  input  1  FIFO empty flag
rx_rd  output  1  one-cycle FIFO pop strobe
seg  output  7  segments {g,f,e,d,c,b,a}, active low
dp  output  1  decimal point, active low
an  output  DIGITS  digit anodes, active low, an[0]=rightmost

Behaviour:
- Reset (clk edge with rst=1): rx_rd=0, seg=7'h7F, dp=1, an=all ones, buffer all blank (0x20), scan index=0, divider=0, FSM=IDLE, dp flags cleared. Reset mid-pop aborts the pop; rx_rd is 0 the next cycle; no buffer update.
- Read FSM, states IDLE, POP, SETTLE:
  - IDLE: if rx_empty=0, capture rx_data this cycle and go to POP; otherwise stay.
  - POP: rx_rd=1 for exactly this one cycle; apply the captured byte to the buffer; go to SETTLE.
  - SETTLE: rx_rd=0; wait one cycle for the FIFO flag to update; go to IDLE.
  - Maximum rate is one byte per 3 cycles. rx_rd is never asserted in two consecutive cycles and never while rx_empty was 1 at capture.
- Byte handling, applied in POP:
  - 0x0D (CR): all digits cleared to blank, all dp flags cleared.
  - 0x2E ('.'): sets the dp flag of digit 0; no shift.
  - Any other byte: shift buffer left (digit k gets digit k-1, dp flag shifts with it); digit 0 gets the byte with its dp flag cleared.
- Decode (active low, {g..a}):
  - '0'=40 '1'=79 '2'=24 '3'=30 '4'=19 '5'=12 '6'=02 '7'=78 '8'=00 '9'=10
  - 'A'/'a'=08 'B'/'b'=03 'C'/'c'=46 'D'/'d'=21 'E'/'e'=06 'F'/'f'=0E
  - '-'=3F; space and any other byte = 7F (blank).
- Scan:
  - Divider counts 0..REFRESH_DIV-1 and wraps, width $clog2(REFRESH_DIV).
  - At terminal count the scan index advances and wraps DIGITS-1 -> 0.
  - seg, dp and an are registered and update in the same cycle from the current index and buffer.
  - Exactly one an bit is low at a time, except all high during reset. First post-reset cycle: an=~1.
  - A buffer update is visible on the next cycle in which its digit is selected. Scan timing is independent of FIFO activity.

Test Plan:
- Reset, idle, REFRESH_DIV=4, DIGITS=4 -> an cycles 1110,1101,1011,0111 every 4 clks; seg=7F throughout; rx_rd never asserts.
- FIFO holds "1234" -> exactly 4 rx_rd pulses, each 3 clks apart; while an=1110 seg=19 ('4'); while an=0111 seg=79 ('1').
- Send "12.3" -> digit1='2' with dp=0 when selected; digit0='3' with dp=1.
- Send "AB", then 0x0D -> after the CR pop, all digits seg=7F and dp=1.
- Send 0x47 ('G') -> the byte is shifted in and digit0 shows 7F.
- Assert rst in the POP cycle -> rx_rd=0 the next cycle, buffer blank; the FIFO byte is not consumed twice and is re-read after reset.
